// File: rtl/gen_gamma_pkg.sv
// gen_gamma_pkg -- shared constants and types for the gamma decoder.
//   GG_SIZE    : default plaintext width.
//   gg_entry_t : output FIFO entry {err, data}. Its data field is GG_SIZE
//                bits wide, so a decoder built with another SIZE needs this
//                constant changed to match.
package gen_gamma_pkg;

  localparam int GG_SIZE = 8;

  typedef struct packed {
    logic               err;
    logic [GG_SIZE-1:0] data;
  } gg_entry_t;

endpackage

// File: rtl/gen_gamma_decoder_subtractor.sv
// gen_gamma_decoder_subtractor -- combinational gamma removal.
//   data_i [SIZE:0]   : coded word {carry, sum}
//   key_i  [SIZE-1:0] : gamma key
//   data_o [SIZE-1:0] : decoded plaintext (low bits of the difference)
//   err_o             : result out of range (borrow or bit SIZE set)
module gen_gamma_decoder_subtractor #(
  parameter int SIZE = 8
) (
  input  logic [SIZE:0]   data_i,
  input  logic [SIZE-1:0] key_i,
  output logic [SIZE-1:0] data_o,
  output logic            err_o
);

  logic [SIZE+1:0] diff;

  // Two guard bits: the top one catches a borrow, the next one a
  // result that does not fit back into SIZE bits.
  assign diff   = {1'b0, data_i} - {2'b00, key_i};
  assign data_o = diff[SIZE-1:0];
  assign err_o  = diff[SIZE+1] | diff[SIZE];

endmodule

// File: rtl/gen_gamma_decoder.sv
// gen_gamma_decoder -- one-stage gamma decoder feeding an output FIFO.
//   clk, res_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, inp_data {carry,sum}, inp_key
//   out_valid/out_ready : output handshake, out_data + out_err (head entry)
//   err_cnt             : saturating error count, present only when
//                         GEN_GAMMA_DEC_ERR_CNT_EN is defined
// An accepted word sits one cycle in s1, is decoded from s1 and pushed into
// the FIFO on the following edge. in_ready depends on registers only; it
// reserves a FIFO slot for the word held in s1, so a push can never overflow.
module gen_gamma_decoder
  import gen_gamma_pkg::*;
#(
  parameter int SIZE  = GG_SIZE,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE:0]   inp_data,
  input  logic [SIZE-1:0] inp_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic            out_err
`ifdef GEN_GAMMA_DEC_ERR_CNT_EN
  ,
  output logic [7:0]      err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  // stage register
  logic            s1_valid_q, s1_valid_d;
  logic [SIZE:0]   s1_data_q,  s1_data_d;
  logic [SIZE-1:0] s1_key_q,   s1_key_d;

  // FIFO state
  gg_entry_t       mem_q [DEPTH];
  gg_entry_t       mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;

  logic            accept, push, pop;
  logic [AW+1:0]   occupancy;
  logic [SIZE-1:0] dec_data;
  logic            dec_err;
  gg_entry_t       push_entry, head;

  gen_gamma_decoder_subtractor #(.SIZE(SIZE)) subtractor (
    .data_i (s1_data_q),
    .key_i  (s1_key_q),
    .data_o (dec_data),
    .err_o  (dec_err)
  );

  assign occupancy = {1'b0, count_q} + (AW+2)'(s1_valid_q);
  assign in_ready  = occupancy < (AW+2)'(DEPTH);
  assign out_valid = (count_q != '0);

  assign accept = in_valid & in_ready;
  assign push   = s1_valid_q;
  assign pop    = out_valid & out_ready;

  assign push_entry = '{err: dec_err, data: dec_data};
  assign head       = mem_q[rd_ptr_q];

  // Empty FIFO shows zeros rather than whatever stale entry the head holds.
  assign out_data = out_valid ? head.data : '0;
  assign out_err  = out_valid & head.err;

  always_comb begin
    s1_valid_d = accept;
    s1_data_d  = s1_data_q;
    s1_key_d   = s1_key_q;
    if (accept) begin
      s1_data_d = inp_data;
      s1_key_d  = inp_key;
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_key_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_key_q   <= s1_key_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef GEN_GAMMA_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && dec_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
